// File: rtl/cvxif_result_buffer_pkg.sv
// Shared CV-X-IF result/commit types and widths for the result buffer and its kill tracker.
package cvxif_result_buffer_pkg;

    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned X_RFW      = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [X_RFW-1:0]      data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  x_commit_kill;
    } x_commit_t;

endpackage

// File: rtl/cvxif_kill_tracker.sv
// Per-id kill bitmap: commit sets/clears by id, consumers clear, two read ports.
module cvxif_kill_tracker #(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                commit_valid_i,
    input  logic                commit_kill_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic [ID_WIDTH-1:0] new_id_i,
    input  logic                clr_new_i,
    output logic                new_killed_o,
    input  logic [ID_WIDTH-1:0] head_id_i,
    input  logic                clr_head_i,
    output logic                head_killed_o
);

    localparam int unsigned Entries = 2 ** ID_WIDTH;

    logic [Entries-1:0] map_q, map_d;

    always_comb begin
        map_d = map_q;
        if (commit_valid_i) begin
            map_d[commit_id_i] = commit_kill_i;
        end
        // A consumed kill is retired after the commit update so it cannot survive the cycle.
        if (clr_new_i) begin
            map_d[new_id_i] = 1'b0;
        end
        if (clr_head_i) begin
            map_d[head_id_i] = 1'b0;
        end
        if (flush_i) begin
            map_d = '0;
        end
    end

    // A kill landing in the same cycle as the result still suppresses it.
    assign new_killed_o  = map_q[new_id_i] ||
                           (commit_valid_i && commit_kill_i && (commit_id_i == new_id_i));
    assign head_killed_o = map_q[head_id_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/cvxif_result_buffer.sv
// Queues non-stallable coprocessor results towards the core and drops killed instructions.
module cvxif_result_buffer
    import cvxif_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = X_ID_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   copro_valid_i,
    input  x_result_t              copro_result_i,
    output logic                   copro_ready_o,
    input  logic                   x_commit_valid_i,
    input  x_commit_t              x_commit_i,
    output logic                   core_valid_o,
    output x_result_t              core_result_o,
    input  logic                   core_ready_i,
    output logic [$clog2(DEPTH):0] usage_o,
    output logic                   overflow_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned UsageW = PtrW + 1;

    x_result_t           mem_q [DEPTH];
    x_result_t           head;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UsageW-1:0]   usage_q, usage_d;
    logic                overflow_q, overflow_d;
    logic                empty, full, push, pop;
    logic                push_killed, head_kill_bit, head_killed;

    assign head  = mem_q[rd_ptr_q];
    assign empty = (usage_q == '0);
    assign full  = (usage_q == UsageW'(DEPTH));

    cvxif_kill_tracker #(
        .ID_WIDTH (ID_WIDTH)
    ) u_kill_tracker (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .commit_valid_i (x_commit_valid_i),
        .commit_kill_i  (x_commit_i.x_commit_kill),
        .commit_id_i    (x_commit_i.id),
        .new_id_i       (copro_result_i.id),
        .clr_new_i      (copro_valid_i && push_killed),
        .new_killed_o   (push_killed),
        .head_id_i      (head.id),
        .clr_head_i     (head_killed),
        .head_killed_o  (head_kill_bit)
    );

    assign head_killed = !empty && head_kill_bit;

    always_comb begin
        push          = copro_valid_i && !push_killed && !full;
        pop           = !empty && (head_killed || core_ready_i);
        core_valid_o  = !empty && !head_killed;
        core_result_o = core_valid_o ? head : '0;
        copro_ready_o = !full;
        usage_o       = usage_q;
        overflow_o    = overflow_q;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        usage_d    = usage_q;
        overflow_d = overflow_q || (copro_valid_i && !push_killed && full);
        case ({push, pop})
            2'b10:   usage_d = usage_q + 1'b1;
            2'b01:   usage_d = usage_q - 1'b1;
            default: usage_d = usage_q;
        endcase

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            usage_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usage_q    <= usage_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage needs no reset: entries are only observable while usage covers them.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= copro_result_i;
        end
    end

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Randomized + directed bench for cvxif_result_buffer with a queue-level reference model.
module tb_cvxif_result_buffer;
    import cvxif_result_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush_i = 1'b0;
    logic       copro_valid_i = 1'b0;
    x_result_t  copro_result_i = '0;
    logic       copro_ready_o;
    logic       x_commit_valid_i = 1'b0;
    x_commit_t  x_commit_i = '0;
    logic       core_valid_o;
    x_result_t  core_result_o;
    logic       core_ready_i = 1'b0;
    logic [2:0] usage_o;
    logic       overflow_o;

    cvxif_result_buffer #(
        .DEPTH    (DEPTH),
        .ID_WIDTH (X_ID_WIDTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .copro_valid_i    (copro_valid_i),
        .copro_result_i   (copro_result_i),
        .copro_ready_o    (copro_ready_o),
        .x_commit_valid_i (x_commit_valid_i),
        .x_commit_i       (x_commit_i),
        .core_valid_o     (core_valid_o),
        .core_result_o    (core_result_o),
        .core_ready_i     (core_ready_i),
        .usage_o          (usage_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: buffered results in order, kill set by id, sticky overflow.
    x_result_t mq[$];
    bit        km[16];
    bit        movf;
    // Results the model says the core will accept, in order.
    x_result_t sb_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic x_result_t mk(input logic [3:0] id, input logic [31:0] d);
        x_result_t r;
        r.id      = id;
        r.data    = d;
        r.rd      = 5'($urandom);
        r.we      = 1'($urandom);
        r.exc     = 1'($urandom);
        r.exccode = 6'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (km[k]) km[k] = 1'b0;
        movf = 1'b0;
    endtask

    task automatic check_state();
        bit        ev;
        x_result_t er;
        ev = (mq.size() > 0) && !km[mq[0].id];
        er = ev ? mq[0] : '0;
        check("core_valid", 64'(core_valid_o), 64'(ev));
        check("core_result", 64'(core_result_o), 64'(er));
        check("usage", 64'(usage_o), 64'(mq.size()));
        check("copro_ready", 64'(copro_ready_o), 64'(mq.size() < DEPTH));
        check("overflow", 64'(overflow_o), 64'(movf));
    endtask

    // One clock of stimulus: check current state, drive inputs, advance the model.
    task automatic step(input bit cv, input x_result_t r, input bit xv, input bit xk,
                        input logic [3:0] xid, input bit cr, input bit fl);
        bit         full, hv, hd, pk;
        logic [3:0] hid;
        @(negedge clk_i);
        check_state();
        copro_valid_i    = cv;
        copro_result_i   = r;
        x_commit_valid_i = xv;
        x_commit_i.id    = xid;
        x_commit_i.x_commit_kill = xk;
        core_ready_i     = cr;
        flush_i          = fl;
        if (fl) begin
            model_reset();
        end else begin
            full = (mq.size() == DEPTH);
            hv = 1'b0;
            hd = 1'b0;
            hid = '0;
            if (mq.size() > 0) begin
                hid = mq[0].id;
                hd  = km[hid];
                hv  = !hd;
            end
            if (hv && cr) sb_q.push_back(mq[0]);
            pk = cv && (km[r.id] || (xv && xk && (xid == r.id)));
            if (cv && !pk && full) movf = 1'b1;
            if (xv) km[xid] = xk;
            if (pk) km[r.id] = 1'b0;
            if (hd) km[hid] = 1'b0;
            if ((hv && cr) || hd) void'(mq.pop_front());
            if (cv && !pk && !full) mq.push_back(r);
        end
    endtask

    task automatic idle(input bit cr);
        step(1'b0, '0, 1'b0, 1'b0, 4'd0, cr, 1'b0);
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] d, input bit cr);
        step(1'b1, mk(id, d), 1'b0, 1'b0, 4'd0, cr, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every handshake the DUT is about to complete must match the scoreboard head.
    initial begin
        x_result_t exp;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni && core_valid_o && core_ready_i && !flush_i) begin
                check("handshake_expected", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    check("handshake_result", 64'(core_result_o), 64'(exp));
                end
            end
        end
    end

    initial begin
        model_reset();
        #3;
        check("rst_usage", 64'(usage_o), 64'd0);
        check("rst_core_valid", 64'(core_valid_o), 64'd0);
        check("rst_core_result", 64'(core_result_o), 64'd0);
        check("rst_copro_ready", 64'(copro_ready_o), 64'd1);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        #9 rst_ni = 1'b1;

        // Single result, latency 1.
        push(4'd2, 32'h10, 1'b1);
        settle();
        check("t1_valid", 64'(core_valid_o), 64'd1);
        check("t1_data", 64'(core_result_o.data), 64'h10);
        idle(1'b1);
        settle();
        check("t1_empty", 64'(core_valid_o), 64'd0);

        // Backpressure, fill, overflow; drain order is checked by the monitor.
        for (int i = 0; i < 4; i++) push(4'(i), 32'h100 + 32'(i), 1'b0);
        settle();
        check("t2_usage_full", 64'(usage_o), 64'd4);
        check("t2_copro_ready", 64'(copro_ready_o), 64'd0);
        push(4'd4, 32'h104, 1'b0);
        settle();
        check("t2_overflow", 64'(overflow_o), 64'd1);
        check("t2_usage_kept", 64'(usage_o), 64'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);
        settle();
        check("t2_drained", 64'(usage_o), 64'd0);

        // Kill before result arrives; kill bit must be consumed.
        step(1'b0, '0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        push(4'd1, 32'h200, 1'b0);
        settle();
        check("t3_dropped", 64'(usage_o), 64'd0);
        push(4'd1, 32'h201, 1'b0);
        settle();
        check("t3_kill_cleared", 64'(usage_o), 64'd1);
        idle(1'b1);

        // Kill queued head.
        push(4'd5, 32'h305, 1'b0);
        push(4'd6, 32'h306, 1'b0);
        settle();
        check("t4_usage2", 64'(usage_o), 64'd2);
        step(1'b0, '0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        idle(1'b0);
        settle();
        check("t4_usage1", 64'(usage_o), 64'd1);
        check("t4_head_id", 64'(core_result_o.id), 64'd6);
        idle(1'b1);

        // Same-cycle result and kill for one id.
        step(1'b1, mk(4'd3, 32'h403), 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        settle();
        check("t5_no_entry", 64'(usage_o), 64'd0);

        // Flush with entries and overflow pending.
        for (int i = 0; i < 3; i++) push(4'(8 + i), 32'h500 + 32'(i), 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        settle();
        check("t6_flush_usage", 64'(usage_o), 64'd0);
        check("t6_flush_overflow", 64'(overflow_o), 64'd0);
        check("t6_flush_valid", 64'(core_valid_o), 64'd0);
        idle(1'b0);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) push(4'(12 + i), 32'h600 + 32'(i), 1'b0);
        idle(1'b1);
        idle(1'b0);
        #3 rst_ni = 1'b0;
        #1;
        check("t6_arst_valid", 64'(core_valid_o), 64'd0);
        check("t6_arst_usage", 64'(usage_o), 64'd0);
        check("t6_arst_ready", 64'(copro_ready_o), 64'd1);
        check("t6_arst_result", 64'(core_result_o), 64'd0);
        model_reset();
        @(negedge clk_i);
        #3 rst_ni = 1'b1;

        // Randomized traffic with alternating core backpressure phases.
        for (int i = 0; i < 3000; i++) begin
            bit cr;
            cr = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 1)), mk(4'($urandom_range(0, 7)), $urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 7)), cr, ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);
        @(negedge clk_i);
        check_state();
        #3;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
